mat_mult_sequencer: RTL and testbench
=====================================

// Module: mat_mult_sequencer
// PURPOSE
//  Host-facing controller for the NxN matrix datapath. Buffers operand matrices A and B written word-by-word over a
//  simple register bus, then sequences one datapath run: clear, enable for LAT cycles, capture result. The captured
//  result matrix is readable over the same bus. Sits between the Avalon-style host slave and the mat_mult datapath.
// PARAMETERS
//  N       2    matrix dimension; A, B and result are each NxN elements
//  W       27   element width in bits (floating-point word width of the datapath)
//  LAT     8    datapath cycles from first mm_en cycle until mm_result is valid; legal range 1..255
//  AW      $clog2(3*N*N+2)  host address width (derived, do not override)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  host_wr      in   1        write strobe, one cycle per word
//  host_rd      in   1        read strobe, one cycle per word
//  host_addr    in   AW       word address (map below)
//  host_wdata   in   W        write data
//  host_rdata   out  W        read data, registered, valid the cycle after host_rd
//  busy         out  1        high while a run is in progress (not IDLE)
//  mm_en        out  1        datapath enable
//  mm_rst       out  1        datapath synchronous clear, active high
//  mm_mode      out  1        datapath mode, held for the whole run
//  mm_dataa     out  N*N*W    packed A, element [i][j] at ((i*N+j)*W)
//  mm_datab     out  N*N*W    packed B, same packing
//  mm_result    in   N*N*W    datapath result, same packing
// BEHAVIOUR
//  Address map: 0..N*N-1 A[i][j] (R/W); N*N..2N*N-1 B (R/W); 2N*N..3N*N-1 RES (RO); CTRL=3N*N; STATUS=3N*N+1.
//  CTRL write: bit0 start (self-clearing), bit1 mode. CTRL read: {bit1=mode, bit0=0}.
//  STATUS read: bit0 busy, bit1 done (sticky, cleared by a STATUS read), bit2 err (sticky, cleared by a STATUS read).
//  Unmapped reads return 0; unmapped writes are ignored.
//  Reset: all outputs 0; A, B, RES, mode, done and err = 0; FSM = IDLE.
//  FSM:
//   IDLE  -> CLR on CTRL write with bit0=1; mode latched the same cycle.
//   CLR   1 cycle, mm_rst=1, mm_en=0 -> RUN.
//   RUN   mm_en=1 for exactly LAT cycles (counter LAT-1 down to 0) -> CAPT.
//   CAPT  1 cycle, RES <= mm_result, done<=1 -> IDLE.
//  Start-to-IDLE latency is LAT+2 cycles. busy=1 in CLR, RUN and CAPT.
//  During busy: A/B writes and CTRL writes are dropped and err<=1; reads are always served (RES shows old value).
//  mm_dataa and mm_datab are driven continuously from the A/B buffers. mm_mode is driven from latched mode.
//  Same-cycle host_wr and host_rd: the write is performed; the read returns pre-write data.
//  STATUS read coinciding with CAPT: the read returns done=1 (or the pre-existing err); the clear and the new set
//   resolve as set-wins, so done stays 1.
//  Reset mid-run: FSM returns to IDLE asynchronously, RES is cleared, and no done is reported.
//  No arithmetic is performed in this block; elements pass through bit-exact.
// CONFIGURATION
//  MAT_MULT_SEQUENCER_IRQ_EN defined: adds output port irq (1 bit), level-high while done=1 (cleared by STATUS read).
//  Undefined: no irq port; host polls STATUS. All other behaviour is identical.
// STRUCTURE
//  Package mat_mult_pkg: typedef word_t (logic [W-1:0]), state_t enum {IDLE,CLR,RUN,CAPT}, address-offset constants
//   A_BASE, B_BASE, RES_BASE, CTRL_ADDR, STATUS_ADDR, and CTRL/STATUS bit indices.
//  Sub-module mat_mult_opbuf: A/B/RES element storage, write decode and read mux. The top level holds the FSM,
//   the LAT counter and the sticky flags.
// TESTING
//  1 Write A=I (1.0=27'h1FC0000 on the diagonal), B=arbitrary, start with mode 0 -> busy for exactly LAT+2 cycles,
//    mm_rst high 1 cycle, mm_en high LAT cycles; RES read equals the stubbed mm_result.
//  2 Write A[1][0]=27'h0123456 during RUN -> A unchanged, STATUS=3'b101 (err, busy), and a second STATUS read = 3'b001.
//  3 Start while busy -> no second run; the cycle count stays LAT+2; err=1.
//  4 Assert rst_n low at RUN cycle 3 -> mm_en=0 and busy=0 immediately; RES reads 0; done=0.
//  5 Poll STATUS exactly at CAPT -> read returns done=1 and the next STATUS read returns done=1 once more.
//  6 With MAT_MULT_SEQUENCER_IRQ_EN: irq rises the cycle after CAPT and falls after a STATUS read.
//    Without it: build has no irq port.

Source files
------------

// File: rtl/mat_mult_pkg.sv
// Shared types and constants for the mat_mult host sequencer.
//   word_t      : one datapath element at the default width
//   state_t     : sequencer FSM state encoding
//   *_f helpers : host address map for an arbitrary matrix dimension n
//   *_BASE/ADDR : host address map at the default dimension
//   CTRL_*/ST_* : bit positions inside the CTRL and STATUS words
package mat_mult_pkg;

  localparam int unsigned MM_N  = 2;
  localparam int unsigned MM_W  = 27;
  localparam int unsigned CNT_W = 8;   // holds LAT-1 for LAT up to 255

  typedef logic [MM_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    CAPT = 2'd3
  } state_t;

  function automatic int unsigned b_base_f(input int unsigned n);
    return n * n;
  endfunction

  function automatic int unsigned res_base_f(input int unsigned n);
    return 2 * n * n;
  endfunction

  function automatic int unsigned ctrl_addr_f(input int unsigned n);
    return 3 * n * n;
  endfunction

  function automatic int unsigned status_addr_f(input int unsigned n);
    return 3 * n * n + 1;
  endfunction

  localparam int unsigned A_BASE      = 0;
  localparam int unsigned B_BASE      = b_base_f(MM_N);
  localparam int unsigned RES_BASE    = res_base_f(MM_N);
  localparam int unsigned CTRL_ADDR   = ctrl_addr_f(MM_N);
  localparam int unsigned STATUS_ADDR = status_addr_f(MM_N);

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_MODE_BIT  = 1;
  localparam int unsigned ST_BUSY_BIT    = 0;
  localparam int unsigned ST_DONE_BIT    = 1;
  localparam int unsigned ST_ERR_BIT     = 2;

endpackage

// File: rtl/mat_mult_opbuf.sv
// Operand/result element storage for the sequencer.
//   clk, rst_n : clock, async active-low reset (clears A, B and RES)
//   wr_en      : host write strobe, already gated off while a run is active
//   addr/wdata : host word address and data
//   capt_en    : load RES from result this cycle
//   result     : packed datapath result
//   dataa/b    : packed A and B straight from storage
//   rdata_c    : combinational read mux over A, B and RES (0 outside that range)
module mat_mult_opbuf
  import mat_mult_pkg::*;
#(
  parameter int unsigned N  = MM_N,
  parameter int unsigned W  = MM_W,
  parameter int unsigned AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [W-1:0]     wdata,
  input  logic             capt_en,
  input  logic [N*N*W-1:0] result,
  output logic [N*N*W-1:0] dataa,
  output logic [N*N*W-1:0] datab,
  output logic [W-1:0]     rdata_c
);

  localparam int unsigned NE  = N * N;
  localparam int unsigned BB  = b_base_f(N);
  localparam int unsigned RB  = res_base_f(N);

  logic [W-1:0] a_q   [NE];
  logic [W-1:0] a_d   [NE];
  logic [W-1:0] b_q   [NE];
  logic [W-1:0] b_d   [NE];
  logic [W-1:0] res_q [NE];
  logic [W-1:0] res_d [NE];

  // Write decode and result capture.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    for (int unsigned i = 0; i < NE; i++) begin
      if (wr_en && (addr == AW'(A_BASE + i))) a_d[i] = wdata;
      if (wr_en && (addr == AW'(BB + i)))     b_d[i] = wdata;
      if (capt_en)                            res_d[i] = result[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NE; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end

  // Read mux and packed operand views.
  always_comb begin
    rdata_c = '0;
    dataa   = '0;
    datab   = '0;
    for (int unsigned i = 0; i < NE; i++) begin
      if (addr == AW'(A_BASE + i)) rdata_c = a_q[i];
      if (addr == AW'(BB + i))     rdata_c = b_q[i];
      if (addr == AW'(RB + i))     rdata_c = res_q[i];
      dataa[i*W +: W] = a_q[i];
      datab[i*W +: W] = b_q[i];
    end
  end

endmodule

// File: rtl/mat_mult_sequencer.sv
// Host-facing controller for the NxN matrix datapath: buffers A/B, runs the
// datapath (clear, LAT enable cycles, capture) and exposes the result.
//   clk, rst_n          : clock, async active-low reset
//   host_wr/rd/addr/wdata : register-bus strobes, address, write data
//   host_rdata          : registered read data, valid the cycle after host_rd
//   busy                : run in progress
//   mm_en/mm_rst/mm_mode: datapath enable, sync clear, mode
//   mm_dataa/mm_datab   : packed operands, element [i][j] at (i*N+j)*W
//   mm_result           : packed datapath result
//   irq                 : only with MAT_MULT_SEQUENCER_IRQ_EN defined; high while done
module mat_mult_sequencer
  import mat_mult_pkg::*;
#(
  parameter int unsigned N   = MM_N,
  parameter int unsigned W   = MM_W,
  parameter int unsigned LAT = 8,
  localparam int unsigned AW = $clog2(3 * N * N + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_wr,
  input  logic             host_rd,
  input  logic [AW-1:0]    host_addr,
  input  logic [W-1:0]     host_wdata,
  output logic [W-1:0]     host_rdata,
  output logic             busy,
  output logic             mm_en,
  output logic             mm_rst,
  output logic             mm_mode,
  output logic [N*N*W-1:0] mm_dataa,
  output logic [N*N*W-1:0] mm_datab,
  input  logic [N*N*W-1:0] mm_result
`ifdef MAT_MULT_SEQUENCER_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int unsigned RB = res_base_f(N);
  localparam int unsigned CA = ctrl_addr_f(N);
  localparam int unsigned SA = status_addr_f(N);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             en_q, en_d;
  logic             rst_q, rst_d;
  logic [W-1:0]     rdata_q, rdata_d;

  logic             idle_c;
  logic             ab_wr_c;
  logic             ctrl_wr_c;
  logic             status_rd_c;
  logic             buf_wr_c;
  logic [W-1:0]     buf_rdata_c;
  logic [W-1:0]     ctrl_word_c;
  logic [W-1:0]     status_word_c;

  mat_mult_opbuf #(
    .N  (N),
    .W  (W),
    .AW (AW)
  ) u_opbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr_c),
    .addr    (host_addr),
    .wdata   (host_wdata),
    .capt_en (state_q == CAPT),
    .result  (mm_result),
    .dataa   (mm_dataa),
    .datab   (mm_datab),
    .rdata_c (buf_rdata_c)
  );

  // Host access decode; operand writes only land while idle.
  always_comb begin
    idle_c      = (state_q == IDLE);
    ab_wr_c     = host_wr && (host_addr < AW'(RB));
    ctrl_wr_c   = host_wr && (host_addr == AW'(CA));
    status_rd_c = host_rd && (host_addr == AW'(SA));
    buf_wr_c    = host_wr && idle_c;

    ctrl_word_c                = '0;
    ctrl_word_c[CTRL_MODE_BIT] = mode_q;

    // A read landing in CAPT already sees the done being set this cycle.
    status_word_c              = '0;
    status_word_c[ST_BUSY_BIT] = !idle_c;
    status_word_c[ST_DONE_BIT] = done_q || (state_q == CAPT);
    status_word_c[ST_ERR_BIT]  = err_q;
  end

  // Next-state, counter, sticky flags and read data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = done_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    if (status_rd_c) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ctrl_wr_c) begin
          mode_d = host_wdata[CTRL_MODE_BIT];
          if (host_wdata[CTRL_START_BIT]) state_d = CLR;
        end
      end
      CLR: begin
        state_d = RUN;
        cnt_d   = CNT_W'(LAT - 1);
      end
      RUN: begin
        if (cnt_q == '0) state_d = CAPT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CAPT: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Rejected writes during a run; set after clear so a same-cycle set wins.
    if (!idle_c && (ab_wr_c || ctrl_wr_c)) err_d = 1'b1;

    if (host_rd) begin
      if (host_addr == AW'(CA))      rdata_d = ctrl_word_c;
      else if (host_addr == AW'(SA)) rdata_d = status_word_c;
      else                           rdata_d = buf_rdata_c;
    end

    busy_d = (state_d != IDLE);
    en_d   = (state_d == RUN);
    rst_d  = (state_d == CLR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      rst_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      rst_q   <= rst_d;
      rdata_q <= rdata_d;
    end
  end

  assign host_rdata = rdata_q;
  assign busy       = busy_q;
  assign mm_en      = en_q;
  assign mm_rst     = rst_q;
  assign mm_mode    = mode_q;

`ifdef MAT_MULT_SEQUENCER_IRQ_EN
  assign irq = done_q;
`endif

endmodule

// File: tb/tb_mat_mult_sequencer.sv
// Self-checking bench for mat_mult_sequencer (default parameters).
module tb_mat_mult_sequencer;
  import mat_mult_pkg::*;

  localparam int unsigned N   = 2;
  localparam int unsigned W   = 27;
  localparam int unsigned LAT = 8;
  localparam int unsigned AW  = 4;
  localparam int unsigned PW  = N * N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_wr, host_rd;
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_wdata;
  logic [W-1:0]  host_rdata;
  logic          busy, mm_en, mm_rst, mm_mode;
  logic [PW-1:0] mm_dataa, mm_datab, mm_result;
`ifdef MAT_MULT_SEQUENCER_IRQ_EN
  logic          irq;
`endif

  mat_mult_sequencer #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_wr    (host_wr),
    .host_rd    (host_rd),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .busy       (busy),
    .mm_en      (mm_en),
    .mm_rst     (mm_rst),
    .mm_mode    (mm_mode),
    .mm_dataa   (mm_dataa),
    .mm_datab   (mm_datab),
    .mm_result  (mm_result)
`ifdef MAT_MULT_SEQUENCER_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void check_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void check_vec(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Read scoreboard: expected words queued at issue, checked when data is due.
  logic [W-1:0] exp_q  [$];
  string        name_q [$];
  logic         rd_fire;
  logic [W-1:0] sb_exp;
  string        sb_name;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_fire <= 1'b0;
    else        rd_fire <= host_rd;
  end

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_read: got %h expected no read", host_rdata);
      end else begin
        sb_exp  = exp_q.pop_front();
        sb_name = name_q.pop_front();
        check(sb_name, host_rdata, sb_exp);
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic bus_wr(input int unsigned a, input logic [W-1:0] d);
    @(negedge clk);
    host_wr = 1'b1; host_rd = 1'b0; host_addr = AW'(a); host_wdata = d;
    @(negedge clk);
    host_wr = 1'b0;
  endtask

  task automatic bus_rd(input int unsigned a, input logic [W-1:0] e, input string nm);
    @(negedge clk);
    host_wr = 1'b0; host_rd = 1'b1; host_addr = AW'(a);
    push_exp(e, nm);
    @(negedge clk);
    host_rd = 1'b0;
  endtask

  task automatic drive_start(input logic md);
    @(negedge clk);
    host_wr = 1'b1; host_rd = 1'b0; host_addr = AW'(CTRL_ADDR);
    host_wdata = W'({md, 1'b1});
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_int(nm, 1, 0);
  endtask

  // Observe a run from the cycle after start, with one optional bus access injected.
  task automatic run_window(input int inj_cyc, input logic inj_wr, input logic inj_rd,
                            input int unsigned inj_addr, input logic [W-1:0] inj_data,
                            input logic [W-1:0] inj_exp, input string inj_nm,
                            output int busy_c, output int en_c, output int rst_c,
                            output int mode_c, output int first_busy);
    busy_c = 0; en_c = 0; rst_c = 0; mode_c = 0; first_busy = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      host_wr = 1'b0;
      host_rd = 1'b0;
      if (busy) begin
        busy_c++;
        if (first_busy < 0) first_busy = i;
      end
      if (mm_en) en_c++;
      if (mm_rst) rst_c++;
      if (mm_en && mm_mode) mode_c++;
      if (i == inj_cyc) begin
        host_wr = inj_wr; host_rd = inj_rd;
        host_addr = AW'(inj_addr); host_wdata = inj_data;
        if (inj_rd) push_exp(inj_exp, inj_nm);
      end
    end
  endtask

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  exp;
  } vec_t;

  localparam logic [W-1:0] ONE = 27'h1FC0000;

  vec_t          vt [24];
  logic [PW-1:0] a_exp, b_exp, res_pat, res_pat2;
  int            bc, ec, rc, mc, fb;

  initial begin
    vt[0]  = '{1'b1, 1'b0, 4'd0,  ONE,          27'h0};
    vt[1]  = '{1'b1, 1'b0, 4'd1,  27'h0,        27'h0};
    vt[2]  = '{1'b1, 1'b0, 4'd2,  27'h0,        27'h0};
    vt[3]  = '{1'b1, 1'b0, 4'd3,  ONE,          27'h0};
    vt[4]  = '{1'b1, 1'b0, 4'd4,  27'h1234567,  27'h0};
    vt[5]  = '{1'b1, 1'b0, 4'd5,  27'h7654321,  27'h0};
    vt[6]  = '{1'b1, 1'b0, 4'd6,  27'h0ABCDEF,  27'h0};
    vt[7]  = '{1'b1, 1'b0, 4'd7,  27'h5555555,  27'h0};
    vt[8]  = '{1'b1, 1'b0, 4'd8,  27'h7FFFFFF,  27'h0};
    vt[9]  = '{1'b1, 1'b0, 4'd14, 27'h0000033,  27'h0};
    vt[10] = '{1'b0, 1'b1, 4'd0,  27'h0,        ONE};
    vt[11] = '{1'b0, 1'b1, 4'd1,  27'h0,        27'h0};
    vt[12] = '{1'b0, 1'b1, 4'd3,  27'h0,        ONE};
    vt[13] = '{1'b0, 1'b1, 4'd4,  27'h0,        27'h1234567};
    vt[14] = '{1'b0, 1'b1, 4'd7,  27'h0,        27'h5555555};
    vt[15] = '{1'b0, 1'b1, 4'd8,  27'h0,        27'h0};
    vt[16] = '{1'b0, 1'b1, 4'd12, 27'h0,        27'h0};
    vt[17] = '{1'b0, 1'b1, 4'd13, 27'h0,        27'h0};
    vt[18] = '{1'b0, 1'b1, 4'd14, 27'h0,        27'h0};
    vt[19] = '{1'b0, 1'b1, 4'd15, 27'h0,        27'h0};
    vt[20] = '{1'b1, 1'b1, 4'd1,  27'h0000042,  27'h0};
    vt[21] = '{1'b0, 1'b1, 4'd1,  27'h0,        27'h0000042};
    vt[22] = '{1'b1, 1'b0, 4'd1,  27'h0,        27'h0};
    vt[23] = '{1'b0, 1'b1, 4'd1,  27'h0,        27'h0};

    a_exp    = {ONE, 27'h0, 27'h0, ONE};
    b_exp    = {27'h5555555, 27'h0ABCDEF, 27'h7654321, 27'h1234567};
    res_pat  = {27'h0001111, 27'h2222222, 27'h3333333, 27'h4444444};
    res_pat2 = {27'h6060606, 27'h0707070, 27'h1A2B3C4, 27'h7000001};

    rst_n = 1'b0; host_wr = 1'b0; host_rd = 1'b0;
    host_addr = '0; host_wdata = '0; mm_result = '0;
    repeat (2) @(negedge clk);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_mm_en", int'(mm_en), 0);
    check_int("rst_mm_rst", int'(mm_rst), 0);
    check_int("rst_mm_mode", int'(mm_mode), 0);
    check("rst_rdata", host_rdata, '0);
    check_vec("rst_dataa", mm_dataa, '0);
    rst_n = 1'b1;

    // Register map, boundaries and same-cycle read/write.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      host_wr = vt[i].wr; host_rd = vt[i].rd;
      host_addr = vt[i].addr; host_wdata = vt[i].wdata;
      if (vt[i].rd) push_exp(vt[i].exp, $sformatf("vec%0d", i));
    end
    @(negedge clk);
    host_wr = 1'b0; host_rd = 1'b0;
    @(negedge clk);
    check_vec("dataa_packed", mm_dataa, a_exp);
    check_vec("datab_packed", mm_datab, b_exp);

    // Basic run, mode 0.
    mm_result = res_pat;
    drive_start(1'b0);
    run_window(-1, 1'b0, 1'b0, 0, '0, '0, "none", bc, ec, rc, mc, fb);
    check_int("t1_first_busy", fb, 0);
    check_int("t1_busy_cycles", bc, LAT + 2);
    check_int("t1_en_cycles", ec, LAT);
    check_int("t1_rst_cycles", rc, 1);
    check_int("t1_mode_cycles", mc, 0);
    for (int i = 0; i < 4; i++)
      bus_rd(RES_BASE + i, res_pat[i*W +: W], $sformatf("t1_res%0d", i));
    bus_rd(STATUS_ADDR, 27'd2, "t1_status_done");
    bus_rd(STATUS_ADDR, 27'd0, "t1_status_clr");

    // Operand write during RUN is dropped and flagged.
    drive_start(1'b0);
    @(negedge clk);
    host_wr = 1'b0;
    bus_wr(2, 27'h0123456);
    bus_rd(STATUS_ADDR, 27'd5, "t2_status_err_busy");
    bus_rd(STATUS_ADDR, 27'd1, "t2_status_busy");
    wait_idle("t2_idle_timeout");
    bus_rd(2, 27'h0, "t2_a10_unchanged");
    check_vec("t2_dataa", mm_dataa, a_exp);
    bus_rd(STATUS_ADDR, 27'd2, "t2_status_done");

    // Restart attempt while busy, mode 1 run.
    mm_result = res_pat2;
    drive_start(1'b1);
    run_window(2, 1'b1, 1'b0, CTRL_ADDR, 27'd1, '0, "none", bc, ec, rc, mc, fb);
    check_int("t3_busy_cycles", bc, LAT + 2);
    check_int("t3_en_cycles", ec, LAT);
    check_int("t3_mode_cycles", mc, LAT);
    bus_rd(STATUS_ADDR, 27'd6, "t3_status_err_done");
    bus_rd(STATUS_ADDR, 27'd0, "t3_status_clr");
    bus_rd(CTRL_ADDR, 27'd2, "t3_ctrl_mode");
    bus_rd(RES_BASE, res_pat2[W-1:0], "t3_res0");

    // STATUS read landing on CAPT.
    mm_result = res_pat;
    drive_start(1'b0);
    run_window(9, 1'b0, 1'b1, STATUS_ADDR, '0, 27'd3, "t5_status_at_capt",
               bc, ec, rc, mc, fb);
    bus_rd(STATUS_ADDR, 27'd2, "t5_status_done_again");
    bus_rd(STATUS_ADDR, 27'd0, "t5_status_clr");
    bus_rd(CTRL_ADDR, 27'd0, "t5_ctrl_mode0");

    // Reset at RUN cycle 3.
    drive_start(1'b0);
    repeat (4) begin
      @(negedge clk);
      host_wr = 1'b0;
    end
    check_int("t4_en_before", int'(mm_en), 1);
    rst_n = 1'b0;
    #1;
    check_int("t4_en_async", int'(mm_en), 0);
    check_int("t4_busy_async", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      bus_rd(RES_BASE + i, 27'h0, $sformatf("t4_res%0d", i));
    bus_rd(STATUS_ADDR, 27'd0, "t4_status");

`ifdef MAT_MULT_SEQUENCER_IRQ_EN
    drive_start(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      host_wr = 1'b0;
    end
    check_int("t6_irq_at_capt", int'(irq), 0);
    @(negedge clk);
    check_int("t6_irq_after_capt", int'(irq), 1);
    bus_rd(STATUS_ADDR, 27'd2, "t6_status");
    check_int("t6_irq_cleared", int'(irq), 0);
`endif

    repeat (2) @(negedge clk);
    check_int("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
